// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM states.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL_UU = 3'b000;
  localparam logic [2:0] OP_MUL_SS = 3'b001;
  localparam logic [2:0] OP_MUL_SU = 3'b010;
  localparam logic [2:0] OP_DIV_U  = 3'b100;
  localparam logic [2:0] OP_DIV_S  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// Combinational datapath: STEP chained MSB-first shift-add multiply or restoring divide iterations.
module muldiv_step #(
  parameter int unsigned RV   = 16,
  parameter int unsigned STEP = 1
) (
  input  logic          div_i,
  input  logic [RV-1:0] hi_i,
  input  logic [RV-1:0] lo_i,
  input  logic [RV-1:0] mplr_i,
  input  logic [RV-1:0] opnd_i,
  output logic [RV-1:0] hi_o,
  output logic [RV-1:0] lo_o,
  output logic [RV-1:0] mplr_o
);

  logic [2*RV-1:0] acc;
  logic [RV-1:0]   sh;
  logic [RV-1:0]   rem;
  logic [RV-1:0]   quo;
  logic [RV:0]     trial;

  always_comb begin
    acc   = {hi_i, lo_i};
    sh    = mplr_i;
    rem   = hi_i;
    quo   = lo_i;
    trial = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (div_i) begin
        // Trial subtract is one bit wider so the borrow doubles as the quotient bit.
        trial = {rem, quo[RV-1]} - {1'b0, opnd_i};
        if (!trial[RV]) rem = trial[RV-1:0];
        else            rem = {rem[RV-2:0], quo[RV-1]};
        quo = {quo[RV-2:0], ~trial[RV]};
      end else begin
        acc = (acc << 1) + (sh[RV-1] ? (2*RV)'(opnd_i) : '0);
        sh  = sh << 1;
      end
    end
    hi_o   = div_i ? rem : acc[2*RV-1:RV];
    lo_o   = div_i ? quo : acc[RV-1:0];
    mplr_o = sh;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: magnitude datapath with sign fix-up, start/done handshake,
// abort and hi restore port.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned RV   = 16,
  parameter int unsigned STEP = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [RV-1:0] a,
  input  logic [RV-1:0] b,
  input  logic          abort,
  input  logic          hi_we,
  input  logic [RV-1:0] hi_wdata,
  output logic          busy,
  output logic          done,
  output logic [RV-1:0] result,
  output logic [RV-1:0] hi,
  output logic          div0
);

  localparam int unsigned N  = RV / STEP;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RV-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [RV-1:0]   mplr_q, mplr_d, opnd_q, opnd_d;
  logic            is_div_q, is_div_d, dz_q, dz_d;
  logic            neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic            busy_q, busy_d, done_q, done_d, div0_q, div0_d;
  logic [RV-1:0]   result_q, result_d, hi_q, hi_d;

  logic [RV-1:0]   st_hi, st_lo, st_mplr;
  logic            sgn_a, sgn_b, b_zero;
  logic [RV-1:0]   mag_a, mag_b;
  logic [2*RV-1:0] prod, prod_fix;

  // Divide only honours op 01 as signed; multiply also treats a as signed for op 10.
  assign sgn_a  = a[RV-1] & ((op[1:0] == 2'b01) | (~op[2] & (op[1:0] == 2'b10)));
  assign sgn_b  = b[RV-1] & (op[1:0] == 2'b01);
  assign mag_a  = sgn_a ? RV'(-a) : a;
  assign mag_b  = sgn_b ? RV'(-b) : b;
  assign b_zero = (b == '0);

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_lo_q ? -prod : prod;

  muldiv_step #(.RV(RV), .STEP(STEP)) u_step (
    .div_i  (is_div_q),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .mplr_i (mplr_q),
    .opnd_i (opnd_q),
    .hi_o   (st_hi),
    .lo_o   (st_lo),
    .mplr_o (st_mplr)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mplr_d   = mplr_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done_d   = 1'b0;
    div0_d   = div0_q;
    result_d = result_q;
    hi_d     = hi_q;

    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = hi_wdata;
        if (start) begin
          is_div_d = op[2];
          dz_d     = op[2] & b_zero;
          neg_lo_d = sgn_a ^ sgn_b;
          neg_hi_d = sgn_a;
          cnt_d    = '0;
          acc_hi_d = '0;
          // A zero divisor keeps raw a so it can be returned unchanged as the remainder.
          acc_lo_d = op[2] ? (b_zero ? a : mag_a) : '0;
          mplr_d   = mag_b;
          opnd_d   = op[2] ? mag_b : mag_a;
          state_d  = (op[2] & b_zero) ? FIN : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_hi_d = st_hi;
          acc_lo_d = st_lo;
          mplr_d   = st_mplr;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (is_div_q) begin
            div0_d = dz_q;
            if (dz_q) begin
              result_d = '1;
              hi_d     = acc_lo_q;
            end else begin
              result_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
              hi_d     = neg_hi_q ? -acc_hi_q : acc_hi_q;
            end
          end else begin
            {hi_d, result_d} = prod_fix;
            div0_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mplr_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mplr_q   <= mplr_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      hi_q     <= hi_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign div0   = div0_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: STEP=1 and STEP=4 instances against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic        div0;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  op;
  logic [15:0] a, b, hi_wdata;
  logic        start0, abort0, hi_we0, busy0, done0, div0_0;
  logic        start1, abort1, hi_we1, busy1, done1, div0_1;
  logic [15:0] result0, hi0, result1, hi1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1, last0;
  int   bc0, bc1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.RV(16), .STEP(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start0), .op(op), .a(a), .b(b),
    .abort(abort0), .hi_we(hi_we0), .hi_wdata(hi_wdata),
    .busy(busy0), .done(done0), .result(result0), .hi(hi0), .div0(div0_0));

  muldiv_unit #(.RV(16), .STEP(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start1), .op(op), .a(a), .b(b),
    .abort(abort1), .hi_we(hi_we1), .hi_wdata(hi_wdata),
    .busy(busy1), .done(done1), .result(result1), .hi(hi1), .div0(div0_1));

  function automatic void chk(string tag, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", tag, act, req);
    end
  endfunction

  // Reference: plain integer arithmetic on sign-extended operands.
  function automatic exp_t model(logic [2:0] o, logic [15:0] x, logic [15:0] y, int step);
    exp_t   e;
    longint sx, sy, p;
    sx = ((o[1:0] == 2'b01) || (!o[2] && o[1:0] == 2'b10)) ? longint'($signed(x)) : longint'(x);
    sy = (o[1:0] == 2'b01) ? longint'($signed(y)) : longint'(y);
    e.lat  = 16 / step + 1;
    e.div0 = 1'b0;
    if (!o[2]) begin
      p     = sx * sy;
      e.res = p[15:0];
      e.hi  = p[31:16];
    end else if (y == 16'h0) begin
      e.res  = 16'hFFFF;
      e.hi   = x;
      e.div0 = 1'b1;
      e.lat  = 1;
    end else begin
      p     = sx / sy;
      e.res = p[15:0];
      p     = sx % sy;
      e.hi  = p[15:0];
    end
    return e;
  endfunction

  function automatic void check_done(string u, exp_t e, logic [15:0] r, logic [15:0] h,
                                     logic d0, logic bz, int bc);
    chk({u, "_result"}, 32'(r), 32'(e.res));
    chk({u, "_hi"}, 32'(h), 32'(e.hi));
    chk({u, "_div0"}, 32'(d0), 32'(e.div0));
    chk({u, "_latency"}, 32'(bc), 32'(e.lat));
    chk({u, "_busy_at_done"}, 32'(bz), 32'd0);
  endfunction

  always @(negedge clk) begin
    if (!reset_n) bc0 = 0;
    else begin
      if (busy0) bc0++;
      if (done0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL u1_spurious_done: got done=1 result=%0h, required no done", result0);
        end else begin
          e0 = q0.pop_front();
          check_done("u1", e0, result0, hi0, div0_0, busy0, bc0);
        end
        bc0 = 0;
      end else if (!busy0) bc0 = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) bc1 = 0;
    else begin
      if (busy1) bc1++;
      if (done1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL u4_spurious_done: got done=1 result=%0h, required no done", result1);
        end else begin
          e1 = q1.pop_front();
          check_done("u4", e1, result1, hi1, div0_1, busy1, bc1);
        end
        bc1 = 0;
      end else if (!busy1) bc1 = 0;
    end
  end

  task automatic issue(int u, logic [2:0] o, logic [15:0] x, logic [15:0] y, bit push);
    int n = 0;
    while (((u == 0) ? busy0 : busy1) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL issue_wait_u%0d: busy after %0d cycles, required idle", u, n);
    end
    op = o; a = x; b = y;
    if (u == 0) start0 = 1'b1; else start1 = 1'b1;
    if (push) begin
      if (u == 0) begin
        last0 = model(o, x, y, 1);
        q0.push_back(last0);
      end else begin
        q1.push_back(model(o, x, y, 4));
      end
    end
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
  endtask

  task automatic wait_idle(int u);
    int n = 0;
    while (((u == 0) ? (busy0 || q0.size() != 0) : (busy1 || q1.size() != 0)) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_u%0d: still busy or pending after %0d cycles, required idle", u, n);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_done"}, 32'(done0), 32'd0);
    chk({tag, "_result"}, 32'(result0), 32'd0);
    chk({tag, "_hi"}, 32'(hi0), 32'd0);
    chk({tag, "_div0"}, 32'(div0_0), 32'd0);
  endtask

  logic [2:0] ops [5];
  logic [15:0] rx, ry;

  initial begin
    ops = '{OP_MUL_UU, OP_MUL_SS, OP_MUL_SU, OP_DIV_U, OP_DIV_S};
    reset_n = 1'b1;
    {start0, abort0, hi_we0, start1, abort1, hi_we1} = '0;
    op = '0; a = '0; b = '0; hi_wdata = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    chk("reset_u4_busy", 32'(busy1), 32'd0);
    chk("reset_u4_hi", 32'(hi1), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan
    issue(0, OP_MUL_UU, 16'hFFFF, 16'hFFFF, 1);
    issue(0, OP_MUL_SS, 16'hFFFD, 16'h0005, 1);
    issue(0, OP_MUL_SU, 16'hFFFF, 16'hFFFF, 1);
    issue(0, OP_DIV_S, 16'hFFF9, 16'h0002, 1);
    issue(0, OP_DIV_S, 16'h8000, 16'hFFFF, 1);
    issue(0, OP_DIV_U, 16'h1234, 16'h0000, 1);
    issue(0, OP_MUL_UU, 16'h0003, 16'h0007, 1);
    wait_idle(0);

    // Abort mid-multiply keeps prior outputs and produces no done
    issue(0, OP_MUL_UU, 16'h1234, 16'h5678, 0);
    repeat (4) @(posedge clk);
    #1 abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_result", 32'(result0), 32'(last0.res));
    chk("abort_hi", 32'(hi0), 32'(last0.hi));
    repeat (25) @(posedge clk);
    #1;

    // Start and hi_we while busy are ignored
    issue(0, OP_MUL_SS, 16'h8001, 16'h7FFF, 1);
    repeat (3) @(posedge clk);
    #1 start0 = 1'b1; hi_we0 = 1'b1; hi_wdata = 16'h1111; op = OP_DIV_U;
    @(posedge clk); #1;
    start0 = 1'b0; hi_we0 = 1'b0;
    wait_idle(0);
    repeat (20) @(posedge clk);
    #1;

    // hi restore in IDLE, alone and together with start
    hi_wdata = 16'hBEEF; hi_we0 = 1'b1;
    @(posedge clk); #1;
    hi_we0 = 1'b0;
    chk("hi_we_hi", 32'(hi0), 32'h0000BEEF);
    chk("hi_we_result", 32'(result0), 32'(last0.res));
    hi_wdata = 16'hCAFE; hi_we0 = 1'b1;
    issue(0, OP_MUL_UU, 16'h0003, 16'h0004, 1);
    hi_we0 = 1'b0;
    chk("start_hi_we_hi", 32'(hi0), 32'h0000CAFE);
    chk("start_hi_we_busy", 32'(busy0), 32'd1);
    wait_idle(0);

    // Randomized operations with corner operands mixed in
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ry = 16'h0000;
      if ($urandom_range(0, 9) == 0) begin rx = 16'h8000; ry = 16'hFFFF; end
      issue(0, ops[$urandom_range(0, 4)], rx, ry, 1);
    end
    wait_idle(0);

    // STEP=4 instance: latency 5, then a back-to-back start the cycle after done
    issue(1, OP_DIV_U, 16'hFFFF, 16'h0010, 1);
    issue(1, OP_MUL_SS, 16'(($urandom)), 16'(($urandom)), 1);
    for (int i = 0; i < 12; i++) begin
      rx = 16'($urandom);
      ry = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
      issue(1, ops[$urandom_range(0, 4)], rx, ry, 1);
    end
    wait_idle(1);

    // Reset in the middle of a run clears everything at once
    issue(0, OP_MUL_UU, 16'hABCD, 16'h1357, 1);
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_zero("midreset");
    q0.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    issue(0, OP_DIV_S, 16'h8000, 16'h0003, 1);
    wait_idle(0);

    chk("final_q0_empty", 32'(q0.size()), 32'd0);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
